// File: rtl/core_exu_mdu.sv
// Iterative RV32M multiply/divide execute unit: shift-add multiplier (MUL_BPC bits/cycle),
// restoring divider, divide special-case fast paths and a valid/ready result stage.
module core_exu_mdu #(
  parameter int XLEN    = 32,
  parameter int MUL_BPC = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            mdu_rx_valid,
  output logic            mdu_rx_ready,
  input  logic [2:0]      mdu_rx_funct3,
  input  logic [XLEN-1:0] mdu_rx_rs1,
  input  logic [XLEN-1:0] mdu_rx_rs2,
  input  logic [4:0]      mdu_rx_rd_idx,
  input  logic            mdu_flush,
  output logic            mdu_tx_valid,
  input  logic            mdu_tx_ready,
  output logic [XLEN-1:0] mdu_tx_res,
  output logic [4:0]      mdu_tx_rd_idx,
  output logic            mdu_busy
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] MUL_N = CW'(XLEN / MUL_BPC);
  localparam logic [CW-1:0] DIV_N = CW'(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_reg;
  logic [2:0]        funct3_reg;
  logic [4:0]        rd_idx_reg;
  logic              neg_reg;
  logic              special_reg;
  logic [CW-1:0]     cnt_reg;
  logic [XLEN-1:0]   opd_reg;
  // Multiply: {partial high, remaining multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*XLEN-1:0] prod_reg;

  logic rx_fire;
  assign mdu_rx_ready = !mdu_flush && ((state_reg == S_IDLE) || ((state_reg == S_DONE) && mdu_tx_ready));
  assign rx_fire      = mdu_rx_valid && mdu_rx_ready;
  assign mdu_busy     = (state_reg != S_IDLE);

  // Operand decode at accept
  logic            is_div, a_signed, b_signed, sa, sb;
  logic            div_zero, div_ovf, special, neg;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  always_comb begin
    is_div      = mdu_rx_funct3[2];
    a_signed    = is_div ? !mdu_rx_funct3[0] : (mdu_rx_funct3[1:0] == 2'b01 || mdu_rx_funct3[1:0] == 2'b10);
    b_signed    = is_div ? !mdu_rx_funct3[0] : (mdu_rx_funct3[1:0] == 2'b01);
    sa          = a_signed && mdu_rx_rs1[XLEN-1];
    sb          = b_signed && mdu_rx_rs2[XLEN-1];
    a_mag       = sa ? -mdu_rx_rs1 : mdu_rx_rs1;
    b_mag       = sb ? -mdu_rx_rs2 : mdu_rx_rs2;
    div_zero    = is_div && (mdu_rx_rs2 == '0);
    div_ovf     = is_div && !mdu_rx_funct3[0] && (mdu_rx_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                  && (mdu_rx_rs2 == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = mdu_rx_funct3[1] ? mdu_rx_rs1 : '1;
    else if (div_ovf)
      special_res = mdu_rx_funct3[1] ? '0 : mdu_rx_rs1;
    neg         = (is_div && mdu_rx_funct3[1]) ? sa : (sa ^ sb);
  end

  // Multiply step: add opd * low MUL_BPC multiplier bits, then shift right by MUL_BPC
  logic [XLEN+MUL_BPC-1:0] pp_sum [MUL_BPC+1];
  logic [2*XLEN-1:0]       mul_next;

  assign pp_sum[0] = {{MUL_BPC{1'b0}}, prod_reg[2*XLEN-1:XLEN]};
  for (genvar gi = 0; gi < MUL_BPC; gi++) begin : g_pp
    assign pp_sum[gi+1] = pp_sum[gi]
                        + (prod_reg[gi] ? ({{MUL_BPC{1'b0}}, opd_reg} << gi) : '0);
  end
  assign mul_next = {pp_sum[MUL_BPC], prod_reg[XLEN-1:MUL_BPC]};

  // Restoring divide step: one quotient bit per cycle
  logic [XLEN:0]     div_tmp, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    div_tmp  = {prod_reg[2*XLEN-1:XLEN], prod_reg[XLEN-1]};
    div_diff = div_tmp - {1'b0, opd_reg};
    div_ge   = (div_tmp >= {1'b0, opd_reg});
    div_next = {(div_ge ? div_diff[XLEN-1:0] : div_tmp[XLEN-1:0]), prod_reg[XLEN-2:0], div_ge};
  end

  // Sign fixup and word selection
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   div_word, fix_res;

  always_comb begin
    prod_signed = neg_reg ? -prod_reg : prod_reg;
    div_word    = funct3_reg[1] ? prod_reg[2*XLEN-1:XLEN] : prod_reg[XLEN-1:0];
    if (special_reg)
      fix_res = prod_reg[XLEN-1:0];
    else if (funct3_reg[2])
      fix_res = neg_reg ? -div_word : div_word;
    else if (funct3_reg[1:0] == 2'b00)
      fix_res = prod_signed[XLEN-1:0];
    else
      fix_res = prod_signed[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= S_IDLE;
      funct3_reg    <= '0;
      rd_idx_reg    <= '0;
      neg_reg       <= 1'b0;
      special_reg   <= 1'b0;
      cnt_reg       <= '0;
      opd_reg       <= '0;
      prod_reg      <= '0;
      mdu_tx_valid  <= 1'b0;
      mdu_tx_res    <= '0;
      mdu_tx_rd_idx <= '0;
    end else if (mdu_flush) begin
      state_reg    <= S_IDLE;
      mdu_tx_valid <= 1'b0;
    end else begin
      if (mdu_tx_valid && mdu_tx_ready)
        mdu_tx_valid <= 1'b0;
      if (rx_fire) begin
        funct3_reg  <= mdu_rx_funct3;
        rd_idx_reg  <= mdu_rx_rd_idx;
        neg_reg     <= neg;
        special_reg <= special;
        cnt_reg     <= is_div ? DIV_N : MUL_N;
        opd_reg     <= is_div ? b_mag : a_mag;
        prod_reg    <= special ? {{XLEN{1'b0}}, special_res}
                               : {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
        state_reg   <= special ? S_FIX : S_CALC;
      end else begin
        case (state_reg)
          S_CALC: begin
            prod_reg <= funct3_reg[2] ? div_next : mul_next;
            cnt_reg  <= cnt_reg - 1'b1;
            if (cnt_reg == CW'(1))
              state_reg <= S_FIX;
          end
          S_FIX: begin
            mdu_tx_res    <= fix_res;
            mdu_tx_rd_idx <= rd_idx_reg;
            mdu_tx_valid  <= 1'b1;
            state_reg     <= S_DONE;
          end
          S_DONE: begin
            if (mdu_tx_ready)
              state_reg <= S_IDLE;
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/core_exu_mdu.md
Name: core_exu_mdu

Overview:
Parametrised iterative multiply/divide execute unit implementing the RV32M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), sitting beside the integer EXU between IDU and WBU. It uses the same valid/ready pipe handshake and rd_idx pass-through as the EXU. It adds multi-cycle operation, a configurable multiplier radix, divide special-case fast paths and a pipeline flush.

Parameters:
XLEN, 32, operand/result width in bits.
MUL_BPC, 1, multiplier bits retired per cycle; legal values 1, 2, 4; XLEN % MUL_BPC must be 0.

Ports:
clk  input  1  clock.
rstn  input  1  asynchronous active-low reset.
mdu_rx_valid  input  1  IDU offers an operation.
mdu_rx_ready  output  1  MDU accepts this cycle.
mdu_rx_funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
mdu_rx_rs1  input  XLEN  operand a (multiplicand / dividend).
mdu_rx_rs2  input  XLEN  operand b (multiplier / divisor).
mdu_rx_rd_idx  input  5  destination register index.
mdu_flush  input  1  synchronous kill of the in-flight operation.
mdu_tx_valid  output  1  result available to WBU.
mdu_tx_ready  input  1  WBU accepts.
mdu_tx_res  output  XLEN  result.
mdu_tx_rd_idx  output  5  destination index of the result.
mdu_busy  output  1  high whenever state != S_IDLE.

Behaviour:
- Reset: state S_IDLE; mdu_tx_valid, mdu_tx_res, mdu_tx_rd_idx and all internal datapath registers cleared to 0. Reset mid-operation abandons the operation; no result is ever presented.
- States:
  - S_IDLE: accepts a new operation.
  - S_CALC: iterates.
  - S_FIX: sign/selection fixup; registers mdu_tx_res and asserts mdu_tx_valid.
  - S_DONE: holds the result until it is taken.
- mdu_rx_ready = !mdu_flush && (S_IDLE || (S_DONE && mdu_tx_ready)). It is combinational.
- Accept (rx_valid && rx_ready at edge E0):
  - Latch funct3 and rd_idx.
  - Latch operand magnitudes and result sign.
  - Load the iteration counter.
  - Next state is S_CALC, or S_FIX for a divide special case.
- Latency:
  - mdu_tx_valid rises at edge E0+L, where L = N+1.
  - Multiply: N = XLEN/MUL_BPC.
  - Divide normal case: N = XLEN (restoring, 1 quotient bit per cycle).
  - Divide special cases: N = 0, so L = 1.
  - Latency is independent of operand values except for the special cases.
- S_CALC exits to S_FIX after exactly N edges. S_FIX always moves to S_DONE on the next edge.
- S_DONE:
  - mdu_tx_res and mdu_tx_rd_idx are stable while tx_valid && !tx_ready.
  - tx fire without rx fire: go to S_IDLE, tx_valid to 0.
  - tx fire with rx fire on the same edge: accept the new operation, tx_valid to 0, next state S_CALC or S_FIX. The MDU is not pipelined.
- Arithmetic:
  - Signedness of a and b: MULH both signed; MULHSU a signed, b unsigned; MULHU both unsigned; MUL low word is signedness-independent; DIV/REM signed; DIVU/REMU unsigned.
  - The core computes an unsigned 2*XLEN product, or an XLEN quotient and remainder, on magnitudes.
  - Product sign = sa^sb; negate the 2*XLEN product before selecting the word.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - Quotient sign = sa^sb; remainder sign = sa (remainder sign follows the dividend).
- Divide special cases, detected at accept:
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return rs1.
  - Signed overflow (DIV/REM with rs1 = 1<<(XLEN-1) and rs2 = -1): DIV returns rs1; REM returns 0.
- Flush:
  - Highest priority. At the edge where mdu_flush=1, state goes to S_IDLE and tx_valid to 0; tx_res and tx_rd_idx are don't-care.
  - An operation offered in the flush cycle is not accepted.
  - A result in S_DONE is dropped even if tx_ready=1 in that cycle; WBU must qualify with flush.
- mdu_rx_rd_idx = 0 is computed normally; suppressing the write is WBU's job.

Test Plan:
- MUL 7 × 0xFFFFFFFD, tx_ready=1, MUL_BPC=1 → tx_valid at E0+33, res 0xFFFFFFEB, rd_idx echoed. With MUL_BPC=4 the same result arrives at E0+9.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD at E0+33; REM 0xFFFFFFF9/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases, each with L=1: DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Backpressure: tx_ready=0 for 10 cycles after tx_valid → res/rd_idx stable, rx_ready=0, busy=1. Then tx_ready=1 with rx_valid=1 → result taken and new operation accepted on the same edge, tx_valid=0 on the next cycle.
- Flush at E0+10 of a DIV → no tx_valid, busy=0 after the edge, rx_ready=0 in the flush cycle. A MUL offered one cycle later is accepted and completes with the correct result.
